// File: rtl/div_arbiter_pkg.sv
// Shared definitions for the divider arbiter: FSM state encoding and default widths.
package div_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int unsigned DIV_W       = 4;
  localparam int unsigned DIV_TIMEOUT = 31;

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate so ptr+1 is position 0, priority-encode, un-rotate.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [NREQ-1:0] rot;
  int unsigned     base;
  int unsigned     off;

  always_comb begin
    base = (32'(ptr) + 1) % NREQ;
    rot  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      rot[k] = req[IW'((base + k) % NREQ)];
    end
    // Descending scan leaves the lowest set rotated position in off.
    off = 0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      if (rot[k-1]) off = k - 1;
    end
    any = |rot;
    idx = IW'((base + off) % NREQ);
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin scheduler sharing one divider among NREQ requesters, with a
// zero-divisor bypass and a WAIT-state watchdog.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = DIV_W,
  parameter int unsigned TIMEOUT = DIV_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] x_in,
  input  logic [NREQ*W-1:0] y_in,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] ack,
  output logic [W-1:0]    q_out,
  output logic [W-1:0]    r_out,
  output logic            err_out,
  output logic            tmo_out,
  output logic            busy,
  output logic            div_go,
  output logic [W-1:0]    div_x,
  output logic [W-1:0]    div_y,
  input  logic [W-1:0]    div_q,
  input  logic [W-1:0]    div_r,
  input  logic            div_error,
  input  logic            div_done
);

  localparam int unsigned IW  = $clog2(NREQ);
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [W-1:0]    x_q, x_d;
  logic [W-1:0]    y_q, y_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic [W-1:0]    resq_q, resq_d;
  logic [W-1:0]    resr_q, resr_d;
  logic            rese_q, rese_d;
  logic            rest_q, rest_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [W-1:0]    q_out_q, q_out_d;
  logic [W-1:0]    r_out_q, r_out_d;
  logic            err_out_q, err_out_d;
  logic            tmo_out_q, tmo_out_d;

  logic [W-1:0]    x_arr [NREQ];
  logic [W-1:0]    y_arr [NREQ];
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign x_arr[i] = x_in[i*W +: W];
    assign y_arr[i] = y_in[i*W +: W];
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    x_d       = x_q;
    y_d       = y_q;
    wd_d      = wd_q;
    resq_d    = resq_q;
    resr_d    = resr_q;
    rese_d    = rese_q;
    rest_d    = rest_q;
    ack_d     = '0;
    q_out_d   = q_out_q;
    r_out_d   = r_out_q;
    err_out_d = err_out_q;
    tmo_out_d = tmo_out_q;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          idx_d = pick_idx;
          x_d   = x_arr[pick_idx];
          y_d   = y_arr[pick_idx];
          if (y_arr[pick_idx] == '0) begin
            resq_d  = '0;
            resr_d  = '0;
            rese_d  = 1'b1;
            rest_d  = 1'b0;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + 1'b1;
        // done is checked first so it wins over a same-cycle timeout
        if (div_done) begin
          resq_d  = div_q;
          resr_d  = div_r;
          rese_d  = div_error;
          rest_d  = 1'b0;
          state_d = S_RESP;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          resq_d  = '0;
          resr_d  = '0;
          rese_d  = 1'b1;
          rest_d  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        ack_d[idx_q] = 1'b1;
        q_out_d      = resq_q;
        r_out_d      = resr_q;
        err_out_d    = rese_q;
        tmo_out_d    = rest_q;
        ptr_d        = idx_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      ptr_q     <= IW'(NREQ - 1);
      x_q       <= '0;
      y_q       <= '0;
      wd_q      <= '0;
      resq_q    <= '0;
      resr_q    <= '0;
      rese_q    <= 1'b0;
      rest_q    <= 1'b0;
      ack_q     <= '0;
      q_out_q   <= '0;
      r_out_q   <= '0;
      err_out_q <= 1'b0;
      tmo_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      wd_q      <= wd_d;
      resq_q    <= resq_d;
      resr_q    <= resr_d;
      rese_q    <= rese_d;
      rest_q    <= rest_d;
      ack_q     <= ack_d;
      q_out_q   <= q_out_d;
      r_out_q   <= r_out_d;
      err_out_q <= err_out_d;
      tmo_out_q <= tmo_out_d;
    end
  end

  always_comb begin
    grant = '0;
    if (state_q != S_IDLE) grant[idx_q] = 1'b1;
  end

  assign ack     = ack_q;
  assign q_out   = q_out_q;
  assign r_out   = r_out_q;
  assign err_out = err_out_q;
  assign tmo_out = tmo_out_q;
  assign busy    = (state_q != S_IDLE);
  assign div_go  = (state_q == S_ISSUE);
  assign div_x   = x_q;
  assign div_y   = y_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed self-checking bench for div_arbiter with a small latency-programmable divider model.
module tb_div_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] x_in, y_in;
  logic [3:0]  grant, ack;
  logic [3:0]  q_out, r_out;
  logic        err_out, tmo_out, busy, div_go;
  logic [3:0]  div_x, div_y, div_q, div_r;
  logic        div_error, div_done;

  int total = 0;
  int bad   = 0;

  int   dlat       = 2;
  logic hang       = 1'b0;
  logic force_done = 1'b0;
  int   m_cnt;
  logic [3:0] m_q, m_r;
  logic       m_err;

  always #5 clk = ~clk;

  div_arbiter #(.NREQ(4), .W(4), .TIMEOUT(31)) dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .y_in(y_in),
    .grant(grant), .ack(ack), .q_out(q_out), .r_out(r_out),
    .err_out(err_out), .tmo_out(tmo_out), .busy(busy), .div_go(div_go),
    .div_x(div_x), .div_y(div_y), .div_q(div_q), .div_r(div_r),
    .div_error(div_error), .div_done(div_done)
  );

  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0;
      m_q   <= '0;
      m_r   <= '0;
      m_err <= 1'b0;
    end else if (div_go) begin
      m_cnt <= dlat;
      m_q   <= (div_y != 0) ? div_x / div_y : 4'd0;
      m_r   <= (div_y != 0) ? div_x % div_y : 4'd0;
      m_err <= (div_y == 0);
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign div_q     = m_q;
  assign div_r     = m_r;
  assign div_error = m_err;
  assign div_done  = force_done | ((m_cnt == 1) && !hang);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input int limit);
    int n = 0;
    while (grant == 4'b0 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_ack(input int limit);
    int n = 0;
    while (ack == 4'b0 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic set_op(input int i, input logic [3:0] x, input logic [3:0] y);
    x_in[i*4 +: 4] = x;
    y_in[i*4 +: 4] = y;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [3:0] e;
    logic [3:0] eq [4];
    logic [3:0] er [4];
    int acks;
    eq = '{4'd3, 4'd3, 4'd4, 4'd4};
    er = '{4'd0, 4'd1, 4'd0, 4'd1};

    rst = 1'b1; req = '0; x_in = '0; y_in = '0;
    tick(); tick();
    chk("rst_grant", grant, 0);   chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);     chk("rst_go", div_go, 0);
    chk("rst_q", q_out, 0);       chk("rst_err", err_out, 0);
    chk("rst_divx", div_x, 0);    chk("rst_divy", div_y, 0);

    // 1: single request 13/4
    rst = 1'b0; dlat = 2; set_op(0, 4'd13, 4'd4); req = 4'b0001;
    tick();
    chk("t1_grant", grant, 4'b0001); chk("t1_go", div_go, 1);
    chk("t1_busy", busy, 1);
    chk("t1_divx", div_x, 13);       chk("t1_divy", div_y, 4);
    tick(); chk("t1_go_once", div_go, 0);
    tick(); chk("t1_noack_a", ack, 0);
    tick(); chk("t1_noack_b", ack, 0); chk("t1_grant_resp", grant, 4'b0001);
    tick();
    chk("t1_ack", ack, 4'b0001); chk("t1_q", q_out, 3); chk("t1_r", r_out, 1);
    chk("t1_err", err_out, 0);   chk("t1_tmo", tmo_out, 0);
    chk("t1_busy_after", busy, 0); chk("t1_grant_after", grant, 0);
    req = '0;
    tick(); chk("t1_ack_pulse", ack, 0); chk("t1_q_held", q_out, 3);

    // 2: all four requesting from reset, rotation 0,1,2,3,0
    rst = 1'b1; tick(); rst = 1'b0;
    set_op(0, 4'd6, 4'd2); set_op(1, 4'd7, 4'd2);
    set_op(2, 4'd8, 4'd2); set_op(3, 4'd9, 4'd2);
    req = 4'b1111; dlat = 1;
    for (int k = 0; k < 5; k++) begin
      e = 4'b0001 << (k % 4);
      wait_grant(20); chk("rr_grant", grant, e);
      wait_ack(20);   chk("rr_ack", ack, e);
      chk("rr_q", q_out, eq[k % 4]); chk("rr_r", r_out, er[k % 4]);
      if (k == 4) req = '0;
      tick(); chk("rr_ack_once", ack, 0);
    end

    // 3: zero divisor bypass on requester 2
    set_op(2, 4'd5, 4'd0); req = 4'b0100;
    tick();
    chk("t3_grant", grant, 4'b0100); chk("t3_nogo", div_go, 0); chk("t3_noack", ack, 0);
    tick();
    chk("t3_ack", ack, 4'b0100); chk("t3_q", q_out, 0); chk("t3_r", r_out, 0);
    chk("t3_err", err_out, 1);   chk("t3_tmo", tmo_out, 0);
    req = '0; tick();

    // 4: divider never completes, watchdog aborts
    hang = 1'b1; set_op(1, 4'd10, 4'd3); req = 4'b0010;
    tick(); chk("t4_go", div_go, 1);
    acks = 0;
    for (int n = 2; n <= 33; n++) begin
      tick();
      if (ack != 4'b0) acks++;
    end
    chk("t4_early_ack", acks, 0);
    tick();
    chk("t4_ack", ack, 4'b0010); chk("t4_err", err_out, 1); chk("t4_tmo", tmo_out, 1);
    chk("t4_q", q_out, 0); chk("t4_r", r_out, 0);
    req = '0; hang = 1'b0;
    tick();
    set_op(2, 4'd14, 4'd3); req = 4'b0100; dlat = 1;
    wait_ack(20);
    chk("t4_next_ack", ack, 4'b0100); chk("t4_next_q", q_out, 4); chk("t4_next_r", r_out, 2);
    chk("t4_next_err", err_out, 0);   chk("t4_next_tmo", tmo_out, 0);
    req = '0; tick();

    // 5: operand change and req drop during WAIT, then reset mid-WAIT
    set_op(1, 4'd11, 4'd2); req = 4'b0010; dlat = 3;
    tick(); tick();
    set_op(1, 4'd1, 4'd7); req = '0;
    tick(); chk("t5_divx_held", div_x, 11); chk("t5_divy_held", div_y, 2);
    wait_ack(20);
    chk("t5_ack", ack, 4'b0010); chk("t5_q", q_out, 5); chk("t5_r", r_out, 1);
    tick();
    set_op(3, 4'd9, 4'd4); req = 4'b1000; dlat = 5;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("t5_rst_grant", grant, 0); chk("t5_rst_ack", ack, 0);
    chk("t5_rst_busy", busy, 0);   chk("t5_rst_go", div_go, 0);
    chk("t5_rst_q", q_out, 0);     chk("t5_rst_r", r_out, 0);
    chk("t5_rst_err", err_out, 0); chk("t5_rst_tmo", tmo_out, 0);
    chk("t5_rst_divx", div_x, 0);  chk("t5_rst_divy", div_y, 0);
    rst = 1'b0; set_op(0, 4'd7, 4'd7); req = 4'b1001; dlat = 2;
    tick(); chk("t5_ptr_restart", grant, 4'b0001);
    wait_ack(20);
    chk("t5_post_ack", ack, 4'b0001); chk("t5_post_q", q_out, 1); chk("t5_post_r", r_out, 0);
    req = '0; tick();

    // 6: div_done stuck high while idle
    force_done = 1'b1;
    acks = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (ack != 4'b0 || busy) acks++;
    end
    chk("t6_no_spurious", acks, 0);
    set_op(3, 4'd15, 4'd15); req = 4'b1000;
    tick(); chk("t6_grant", grant, 4'b1000); chk("t6_go", div_go, 1); chk("t6_noack", ack, 0);
    wait_ack(20);
    chk("t6_ack", ack, 4'b1000); chk("t6_q", q_out, 1); chk("t6_r", r_out, 0);
    chk("t6_err", err_out, 0);
    req = '0; force_done = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
